// File: rtl/beam_pkg.sv
// -----------------------------------------------------------------------------
// beam_pkg
// Shared types and constants for the beam scan controller slice.
//   scan_state_e   : controller FSM states
//   PCM_W          : microphone PCM sample width
//   NUM_MICS       : number of channels summed by the beamformer
//   SEL_W          : width of the delay-bank preset index
//   SETTLE_W       : width of the settle sample count
//   SUM_W_DEF      : width of the signed beam sum (PCM plus channel growth)
//   last_dir_index : index of the final preset for a given preset count
// -----------------------------------------------------------------------------
package beam_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2,
      ST_COMPARE = 2'd3
   } scan_state_e;

   localparam int PCM_W     = 19;
   localparam int NUM_MICS  = 8;
   localparam int SEL_W     = 5;
   localparam int SETTLE_W  = 6;

   // Summing NUM_MICS channels grows the word by log2(NUM_MICS) bits.
   localparam int SUM_W_DEF = PCM_W + $clog2(NUM_MICS);

   function automatic logic [SEL_W-1:0] last_dir_index(input int num_dirs);
      return SEL_W'(num_dirs - 1);
   endfunction

endpackage

// File: rtl/beam_scan_controller_if.sv
// -----------------------------------------------------------------------------
// beam_scan_controller_if
// Bundles the scan request, the sample stream and the scan result.
//   start, abort           : scan request / cancel strobes (host -> controller)
//   dwell_samples          : measured samples per preset
//   settle_samples         : samples discarded after each preset change
//   sample_valid, beam_sum : PCM sample strobe and signed beam sum
//   delay_select           : preset index driven to the delay bank
//   busy, done             : scan in progress / one-cycle completion pulse
//   best_dir, best_energy  : committed result of the last completed scan
// Modports: master = host/sample side, slave = controller.
// -----------------------------------------------------------------------------
interface beam_scan_controller_if
   import beam_pkg::*;
#(
   parameter int SUM_W   = SUM_W_DEF,
   parameter int DWELL_W = 16,
   parameter int ACC_W   = 40
);

   logic                       start;
   logic                       abort;
   logic [DWELL_W-1:0]         dwell_samples;
   logic [SETTLE_W-1:0]        settle_samples;
   logic                       sample_valid;
   logic signed [SUM_W-1:0]    beam_sum;
   logic [SEL_W-1:0]           delay_select;
   logic                       busy;
   logic                       done;
   logic [SEL_W-1:0]           best_dir;
   logic [ACC_W-1:0]           best_energy;

   modport master (
      output start, abort, dwell_samples, settle_samples, sample_valid, beam_sum,
      input  delay_select, busy, done, best_dir, best_energy
   );

   modport slave (
      input  start, abort, dwell_samples, settle_samples, sample_valid, beam_sum,
      output delay_select, busy, done, best_dir, best_energy
   );

endinterface

// File: rtl/abs_accumulator.sv
// -----------------------------------------------------------------------------
// abs_accumulator
// Accumulates the magnitude of a signed sample, saturating at all-ones.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : clears the accumulator (wins over en)
//   en       : adds |din| this cycle
//   din      : signed sample
//   acc      : registered accumulator value
// -----------------------------------------------------------------------------
module abs_accumulator #(
   parameter int SUM_W = 22,
   parameter int ACC_W = 40
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [SUM_W-1:0] din,
   output logic [ACC_W-1:0]        acc
);

   // Two's-complement magnitude; the most-negative input maps to 2^(SUM_W-1),
   // which still fits because the result is treated as unsigned.
   function automatic logic [SUM_W-1:0] magnitude(input logic [SUM_W-1:0] v);
      logic [SUM_W-1:0] one_v;
      one_v = {{(SUM_W-1){1'b0}}, 1'b1};
      if (v[SUM_W-1]) begin
         return ~v + one_v;
      end else begin
         return v;
      end
   endfunction

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] acc_nxt_s;
   logic [ACC_W:0]   sum_s;

   // Next accumulator value: clear, saturating add, or hold.
   always_comb begin
      sum_s     = {1'b0, acc_r} + {{(ACC_W+1-SUM_W){1'b0}}, magnitude(din)};
      acc_nxt_s = acc_r;
      if (clr) begin
         acc_nxt_s = {ACC_W{1'b0}};
      end else if (en) begin
         // A carry out of the top bit means the true sum no longer fits.
         acc_nxt_s = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
      end else begin
         acc_nxt_s = acc_r;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r <= {ACC_W{1'b0}};
      end else begin
         acc_r <= acc_nxt_s;
      end
   end

   assign acc = acc_r;

endmodule

// File: rtl/beam_scan_controller.sv
// -----------------------------------------------------------------------------
// beam_scan_controller
// Steps the delay bank through NUM_DIRS steering presets, discards the settle
// samples after each change, accumulates |beam_sum| over the dwell window and
// locks the delay bank onto the loudest preset.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : beam_scan_controller_if.slave (request, samples, result)
// -----------------------------------------------------------------------------
module beam_scan_controller
   import beam_pkg::*;
#(
   parameter int NUM_DIRS = 4,
   parameter int SUM_W    = SUM_W_DEF,
   parameter int DWELL_W  = 16,
   parameter int ACC_W    = 40
) (
   input  logic                   clk,
   input  logic                   rst,
   beam_scan_controller_if.slave  bus
);

   localparam logic [SEL_W-1:0]    LAST_DIR    = last_dir_index(NUM_DIRS);
   localparam logic [SEL_W-1:0]    DIR_ZERO    = {SEL_W{1'b0}};
   localparam logic [SEL_W-1:0]    DIR_ONE     = {{(SEL_W-1){1'b0}}, 1'b1};
   localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};
   localparam logic [SETTLE_W-1:0] SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};
   localparam logic [DWELL_W-1:0]  DWELL_ZERO  = {DWELL_W{1'b0}};
   localparam logic [DWELL_W-1:0]  DWELL_ONE   = {{(DWELL_W-1){1'b0}}, 1'b1};
   localparam logic [ACC_W-1:0]    ACC_ZERO    = {ACC_W{1'b0}};

   scan_state_e         state_r,       state_nxt_s;
   logic [SEL_W-1:0]    dir_r,         dir_nxt_s;
   logic [SETTLE_W-1:0] settle_cnt_r,  settle_cnt_nxt_s;
   logic [SETTLE_W-1:0] settle_cap_r,  settle_cap_nxt_s;
   logic [DWELL_W-1:0]  dwell_cnt_r,   dwell_cnt_nxt_s;
   logic [DWELL_W-1:0]  dwell_cap_r,   dwell_cap_nxt_s;
   logic [SEL_W-1:0]    work_dir_r,    work_dir_nxt_s;
   logic [ACC_W-1:0]    work_energy_r, work_energy_nxt_s;
   logic [SEL_W-1:0]    best_dir_r,    best_dir_nxt_s;
   logic [ACC_W-1:0]    best_energy_r, best_energy_nxt_s;
   logic [SEL_W-1:0]    delay_sel_r,   delay_sel_nxt_s;
   logic                busy_r,        busy_nxt_s;
   logic                done_r,        done_nxt_s;
   logic                acc_clr_s;
   logic                acc_en_s;
   logic [ACC_W-1:0]    acc_s;

   abs_accumulator #(
      .SUM_W (SUM_W),
      .ACC_W (ACC_W)
   ) u_acc (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr_s),
      .en  (acc_en_s),
      .din (bus.beam_sum),
      .acc (acc_s)
   );

   // Next-state, counter, best-tracking and output logic.
   always_comb begin
      state_nxt_s       = state_r;
      dir_nxt_s         = dir_r;
      settle_cnt_nxt_s  = settle_cnt_r;
      settle_cap_nxt_s  = settle_cap_r;
      dwell_cnt_nxt_s   = dwell_cnt_r;
      dwell_cap_nxt_s   = dwell_cap_r;
      work_dir_nxt_s    = work_dir_r;
      work_energy_nxt_s = work_energy_r;
      best_dir_nxt_s    = best_dir_r;
      best_energy_nxt_s = best_energy_r;
      done_nxt_s        = 1'b0;
      acc_clr_s         = 1'b0;
      acc_en_s          = 1'b0;

      case (state_r)
         ST_IDLE: begin
            // abort beats start, so start+abort together does nothing.
            if (bus.start && !bus.abort) begin
               settle_cap_nxt_s  = bus.settle_samples;
               dwell_cap_nxt_s   = (bus.dwell_samples == DWELL_ZERO) ? DWELL_ONE
                                                                     : bus.dwell_samples;
               settle_cnt_nxt_s  = SETTLE_ZERO;
               dwell_cnt_nxt_s   = DWELL_ZERO;
               dir_nxt_s         = DIR_ZERO;
               work_dir_nxt_s    = DIR_ZERO;
               work_energy_nxt_s = ACC_ZERO;
               acc_clr_s         = 1'b1;
               state_nxt_s       = ST_SETTLE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end

         ST_SETTLE: begin
            if (bus.abort) begin
               settle_cnt_nxt_s = SETTLE_ZERO;
               state_nxt_s      = ST_IDLE;
            end else if (settle_cap_r == SETTLE_ZERO) begin
               // Zero settle: one pass-through cycle, the sample is not used.
               state_nxt_s = ST_MEASURE;
            end else if (bus.sample_valid) begin
               if (settle_cnt_r + SETTLE_ONE == settle_cap_r) begin
                  settle_cnt_nxt_s = SETTLE_ZERO;
                  state_nxt_s      = ST_MEASURE;
               end else begin
                  settle_cnt_nxt_s = settle_cnt_r + SETTLE_ONE;
               end
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end

         ST_MEASURE: begin
            if (bus.abort) begin
               dwell_cnt_nxt_s = DWELL_ZERO;
               state_nxt_s     = ST_IDLE;
            end else if (bus.sample_valid) begin
               acc_en_s = 1'b1;
               if (dwell_cnt_r + DWELL_ONE == dwell_cap_r) begin
                  dwell_cnt_nxt_s = DWELL_ZERO;
                  state_nxt_s     = ST_COMPARE;
               end else begin
                  dwell_cnt_nxt_s = dwell_cnt_r + DWELL_ONE;
               end
            end else begin
               state_nxt_s = ST_MEASURE;
            end
         end

         ST_COMPARE: begin
            if (bus.abort) begin
               state_nxt_s = ST_IDLE;
            end else begin
               // Strictly greater: on a tie the earlier (lower) preset stays.
               if (acc_s > work_energy_r) begin
                  work_dir_nxt_s    = dir_r;
                  work_energy_nxt_s = acc_s;
               end else begin
                  work_dir_nxt_s    = work_dir_r;
                  work_energy_nxt_s = work_energy_r;
               end
               if (dir_r == LAST_DIR) begin
                  best_dir_nxt_s    = work_dir_nxt_s;
                  best_energy_nxt_s = work_energy_nxt_s;
                  done_nxt_s        = 1'b1;
                  state_nxt_s       = ST_IDLE;
               end else begin
                  dir_nxt_s   = dir_r + DIR_ONE;
                  acc_clr_s   = 1'b1;
                  state_nxt_s = ST_SETTLE;
               end
            end
         end

         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      // Outputs are computed from the next state so they register in step
      // with it; in IDLE the delay bank stays locked on the committed winner.
      busy_nxt_s      = (state_nxt_s != ST_IDLE);
      delay_sel_nxt_s = (state_nxt_s == ST_IDLE) ? best_dir_nxt_s : dir_nxt_s;
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         dir_r         <= DIR_ZERO;
         settle_cnt_r  <= SETTLE_ZERO;
         settle_cap_r  <= SETTLE_ZERO;
         dwell_cnt_r   <= DWELL_ZERO;
         dwell_cap_r   <= DWELL_ZERO;
         work_dir_r    <= DIR_ZERO;
         work_energy_r <= ACC_ZERO;
         best_dir_r    <= DIR_ZERO;
         best_energy_r <= ACC_ZERO;
         delay_sel_r   <= DIR_ZERO;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         dir_r         <= dir_nxt_s;
         settle_cnt_r  <= settle_cnt_nxt_s;
         settle_cap_r  <= settle_cap_nxt_s;
         dwell_cnt_r   <= dwell_cnt_nxt_s;
         dwell_cap_r   <= dwell_cap_nxt_s;
         work_dir_r    <= work_dir_nxt_s;
         work_energy_r <= work_energy_nxt_s;
         best_dir_r    <= best_dir_nxt_s;
         best_energy_r <= best_energy_nxt_s;
         delay_sel_r   <= delay_sel_nxt_s;
         busy_r        <= busy_nxt_s;
         done_r        <= done_nxt_s;
      end
   end

   assign bus.delay_select = delay_sel_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.best_dir     = best_dir_r;
   assign bus.best_energy  = best_energy_r;

endmodule

// File: tb/tb_beam_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_beam_scan_controller
// Directed and randomized scans of beam_scan_controller. The sample source
// models the acoustics: beam_sum depends on the preset currently selected, so
// every preset's energy is |level| x dwell (saturated) no matter how the
// strobes are spaced.
// -----------------------------------------------------------------------------
module tb_beam_scan_controller;
   import beam_pkg::*;

   localparam int  N   = 4;
   localparam int  SW  = 22;
   localparam int  DW  = 16;
   localparam int  AW  = 24;
   localparam longint ACC_MAX = (longint'(1) << AW) - 1;
   localparam int  MAX_NEG = 2097152; // 2^(SW-1)

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   beam_scan_controller_if #(.SUM_W(SW), .DWELL_W(DW), .ACC_W(AW)) bus ();

   beam_scan_controller #(
      .NUM_DIRS (N),
      .SUM_W    (SW),
      .DWELL_W  (DW),
      .ACC_W    (AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int pat [N];
   bit rand_sign = 1'b0;
   int spike     = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one cycle of sample-source inputs for the currently selected preset.
   task automatic drive_sample(input int density);
      int sel;
      int v;
      int m;
      sel = int'(bus.delay_select);
      v   = (sel < N) ? pat[sel] : 0;
      if (rand_sign) begin
         m = (v < 0) ? -v : v;
         v = (($urandom_range(1) == 1) || (m == MAX_NEG)) ? -m : m;
      end
      if (spike != 0) begin
         v     = spike;
         spike = 0;
      end
      bus.sample_valid = ($urandom_range(99) < density);
      bus.beam_sum     = SW'(v);
   endtask

   task automatic tick(input int density);
      drive_sample(density);
      @(posedge clk);
      #1;
   endtask

   function automatic longint exp_energy(input int k, input int dwell);
      longint m;
      longint e;
      m = (pat[k] < 0) ? -longint'(pat[k]) : longint'(pat[k]);
      e = m * ((dwell == 0) ? 1 : dwell);
      return (e > ACC_MAX) ? ACC_MAX : e;
   endfunction

   // Loudest preset, first one wins on equal energy.
   task automatic model_best(input int dwell, output int bd, output longint be);
      bd = 0;
      be = exp_energy(0, dwell);
      for (int k = 1; k < N; k++) begin
         if (exp_energy(k, dwell) > be) begin
            bd = k;
            be = exp_energy(k, dwell);
         end
      end
   endtask

   // Pulse start, optionally re-pulse it mid-scan, wait for done (bounded).
   task automatic run_scan(input int dwell, input int settle, input int density,
                           input int restart_at, input int first_spike, output int lat);
      int cyc;
      bus.dwell_samples  = DW'(dwell);
      bus.settle_samples = 6'(settle);
      bus.start          = 1'b1;
      tick(density);
      bus.start          = 1'b0;
      bus.dwell_samples  = DW'($urandom_range(100, 65535));
      bus.settle_samples = 6'($urandom_range(20, 63));
      check("start_busy", 64'(bus.busy), 64'd1);
      check("start_sel", 64'(bus.delay_select), 64'd0);
      spike = first_spike;
      cyc   = 1;
      while (bus.done !== 1'b1 && cyc < 5000) begin
         bus.start = (cyc == restart_at);
         tick(density);
         bus.start = 1'b0;
         cyc++;
      end
      check("scan_done", 64'(bus.done), 64'd1);
      lat = cyc;
   endtask

   task automatic check_result(input string tag, input int dwell);
      int     bd;
      longint be;
      model_best(dwell, bd, be);
      check({tag, "_best_dir"}, 64'(bus.best_dir), 64'(bd));
      check({tag, "_best_energy"}, 64'(bus.best_energy), 64'(be));
      check({tag, "_delay_sel"}, 64'(bus.delay_select), 64'(bd));
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      tick(100);
      check({tag, "_done_low"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      int  lat;
      int  dw;
      int  st;
      int  dens;
      bit  seen;

      bus.start          = 1'b0;
      bus.abort          = 1'b0;
      bus.dwell_samples  = '0;
      bus.settle_samples = '0;
      bus.sample_valid   = 1'b0;
      bus.beam_sum       = '0;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_sel", 64'(bus.delay_select), 64'd0);
      check("rst_best_dir", 64'(bus.best_dir), 64'd0);
      check("rst_best_energy", 64'(bus.best_energy), 64'd0);
      rst = 1'b1;
      tick(0);

      // Preset 1 is loudest: 300*8 = 2400.
      pat = '{100, -300, 100, 100};
      run_scan(8, 2, 100, 0, 0, lat);
      check("t1_latency", 64'(lat), 64'(N * (2 + 8 + 1) + 1));
      check_result("t1", 8);

      // All equal: lowest index keeps the tie; start while busy is ignored.
      pat = '{50, 50, 50, 50};
      run_scan(5, 1, 100, 10, 0, lat);
      check("t2_latency", 64'(lat), 64'(N * (1 + 5 + 1) + 1));
      check_result("t2", 5);

      // Most-negative input every sample: 16 * 2^21 saturates a 24-bit sum.
      pat = '{-MAX_NEG, -MAX_NEG, -MAX_NEG, -MAX_NEG};
      run_scan(16, 1, 100, 0, 0, lat);
      check_result("t3_sat", 16);

      // Scan that picks preset 3, then abort during MEASURE of preset 2.
      pat = '{10, 20, 30, 40};
      run_scan(8, 2, 100, 0, 0, lat);
      check_result("t4_prior", 8);
      pat = '{400, 300, 200, 100};
      bus.dwell_samples  = DW'(8);
      bus.settle_samples = 6'(2);
      bus.start          = 1'b1;
      tick(100);
      bus.start = 1'b0;
      for (int i = 0; i < 200 && bus.delay_select != 5'd2; i++) begin
         tick(100);
      end
      check("t4_reach_dir2", 64'(bus.delay_select), 64'd2);
      repeat (4) tick(100);
      bus.abort = 1'b1;
      tick(100);
      bus.abort = 1'b0;
      check("t4_abort_busy", 64'(bus.busy), 64'd0);
      check("t4_abort_sel", 64'(bus.delay_select), 64'd3);
      check("t4_abort_best_dir", 64'(bus.best_dir), 64'd3);
      check("t4_abort_best_energy", 64'(bus.best_energy), 64'd320);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick(100);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check("t4_no_done", 64'(seen), 64'd0);

      // start together with abort in IDLE does nothing.
      bus.dwell_samples = DW'(4);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick(100);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("t5_busy", 64'(bus.busy), 64'd0);
      repeat (3) tick(100);
      check("t5_busy_later", 64'(bus.busy), 64'd0);
      check("t5_sel", 64'(bus.delay_select), 64'd3);

      // Dwell 0 behaves as dwell 1.
      pat = '{7, -9, 3, 5};
      run_scan(0, 3, 100, 0, 0, lat);
      check("t6_latency", 64'(lat), 64'(N * (3 + 1 + 1) + 1));
      check_result("t6_dwell0", 0);

      // Settle 0: the sample during the pass-through cycle must be dropped.
      pat = '{100, 200, 150, 50};
      run_scan(4, 0, 100, 0, -MAX_NEG, lat);
      check_result("t7_settle0", 4);

      // Reset in the middle of SETTLE clears every output at once.
      pat = '{1, 2, 3, 4};
      bus.dwell_samples  = DW'(8);
      bus.settle_samples = 6'(5);
      bus.start          = 1'b1;
      tick(100);
      bus.start = 1'b0;
      tick(100);
      check("t8_pre_busy", 64'(bus.busy), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("t8_rst_busy", 64'(bus.busy), 64'd0);
      check("t8_rst_sel", 64'(bus.delay_select), 64'd0);
      check("t8_rst_best_dir", 64'(bus.best_dir), 64'd0);
      check("t8_rst_best_energy", 64'(bus.best_energy), 64'd0);
      check("t8_rst_done", 64'(bus.done), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      tick(100);
      run_scan(6, 3, 100, 0, 0, lat);
      check("t8_latency", 64'(lat), 64'(N * (3 + 6 + 1) + 1));
      check_result("t8_after", 6);

      // Randomized levels, signs, dwell/settle and strobe density.
      rand_sign = 1'b1;
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < N; k++) begin
            pat[k] = int'($urandom_range(0, MAX_NEG));
            if ($urandom_range(1) == 1) pat[k] = -pat[k];
         end
         dw   = int'($urandom_range(0, 20));
         st   = int'($urandom_range(1, 5));
         dens = (it % 2 == 0) ? 100 : int'($urandom_range(40, 99));
         run_scan(dw, st, dens, int'($urandom_range(1, 10)), 0, lat);
         if (dens == 100) begin
            check("rand_latency", 64'(lat), 64'(N * (st + ((dw == 0) ? 1 : dw) + 1) + 1));
         end
         check_result("rand", dw);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/beam_scan_controller.md
# beam_scan_controller

Sequences the eight-channel delay-and-sum beamformer through its stored steering presets to find the loudest direction. Drives `delay_select` of the delay bank one preset at a time, discards samples while the delay lines refill, then accumulates beam-output magnitude. It locks the delay bank onto the preset with the highest energy. Sits between the PCM sample strobe, the delay bank and the channel summer, and reports the result to the host or control logic.

## Interface
- `NUM_DIRS`, default 4: number of presets scanned, 0..NUM_DIRS-1; range 1..32.
- `SUM_W`, default 22: width of signed beam sum (19-bit PCM plus 3 bits of 8-channel growth).
- `DWELL_W`, default 16: width of the dwell count.
- `ACC_W`, default 40: width of the energy accumulator.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a scan; ignored while `busy`.
- `abort`  in  1  single-cycle request to cancel a running scan.
- `dwell_samples`  in  DWELL_W  measured samples per preset; captured at start.
- `settle_samples`  in  6  samples discarded after each preset change; captured at start.
- `sample_valid`  in  1  one-cycle strobe per PCM sample.
- `beam_sum`  in  SUM_W  signed sum of the delayed channels; valid with `sample_valid`.
- `delay_select`  out  5  preset index to the delay bank.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse on scan completion.
- `best_dir`  out  5  winning preset of the last completed scan.
- `best_energy`  out  ACC_W  accumulated energy of `best_dir`.

## Operation
- Reset: all outputs are 0, state IDLE, all counters 0.
- States: IDLE, SETTLE, MEASURE, COMPARE.
- IDLE
  - `start` captures `dwell_samples` and `settle_samples`.
  - A captured dwell of 0 is forced to 1.
  - Clears `dir`, accumulator and the working best (energy 0, index 0), then goes to SETTLE.
- SETTLE
  - `delay_select` = `dir`.
  - Each `sample_valid` increments the settle count.
  - When the count reaches the captured settle value, go to MEASURE. With settle 0, pass through in one cycle with no sample consumed.
- MEASURE
  - Each `sample_valid` adds |`beam_sum`| to the accumulator.
  - The magnitude of the most-negative value is 2^(SUM_W-1) and fits unsigned SUM_W.
  - The accumulator saturates at all-ones; it never wraps.
  - On the dwell-th sample, go to COMPARE.
- COMPARE (one cycle)
  - If accumulator > working best energy (strictly), the working best becomes (`dir`, accumulator). On a tie the lower index wins.
  - If `dir` = NUM_DIRS-1: commit the working best to `best_dir`/`best_energy`, pulse `done`, go to IDLE.
  - Otherwise: `dir`+1, clear the accumulator, go to SETTLE.
- `abort` in SETTLE/MEASURE/COMPARE
  - Go to IDLE next cycle, with no `done`.
  - `best_dir`/`best_energy` keep the previous committed result, and `delay_select` returns to `best_dir`.
- Priority: `abort` beats `start`. Simultaneous `start`+`abort` in IDLE is a no-op.
- `sample_valid` in IDLE or COMPARE is ignored and is not carried over.
- In IDLE, `delay_select` = `best_dir`, so the lock holds.

## Timing
- All outputs are registered.
- `start` at cycle t: at t+1 `busy`=1, `delay_select`=0, state SETTLE.
- The accumulation of a sample is visible the cycle after its `sample_valid`.
- COMPARE follows the cycle after the last dwell sample and lasts one cycle.
- Final compare at cycle c:
  - At c+1, `done`=1, `busy`=0, and `best_dir`, `best_energy` and `delay_select` all show the new winner.
  - At c+2, `done`=0.
- Scan length, with samples strobed every cycle: NUM_DIRS × (settle + dwell + 1) + 1 cycles from `start` to `done`.
- `abort` at t: at t+1 `busy`=0 and `delay_select`=`best_dir`.
- Reset asserted mid-scan: all outputs go to 0 immediately; no `done`.

## Structure
- Package `beam_pkg` holds:
  - the state enum;
  - `PCM_W`=19, `NUM_MICS`=8, `SEL_W`=5, `SETTLE_W`=6;
  - `SUM_W` derivation (PCM_W + log2 NUM_MICS).
- One sub-module, `abs_accumulator`: signed input, magnitude, saturating add, with clear and enable.
- FSM, counters and best-tracking stay in the top.

## Test plan
- Constant `beam_sum`=+100 for presets 0,2,3 and −300 for preset 1; dwell 8, settle 2 → `best_dir`=1, `best_energy`=2400, one `done` pulse.
- All presets equal (+50) → `best_dir`=0 (tie keeps lowest index), `best_energy`=50×dwell.
- `beam_sum`=−2^21 every sample, ACC_W=24, dwell 16 → accumulator saturates at 2^24−1 with no wrap.
- `abort` during MEASURE of preset 2 after a prior scan that chose preset 3 → `busy`=0 next cycle, `delay_select`=3, no `done`, `best_dir` unchanged.
- `start` while busy, and `start`+`abort` in IDLE → both ignored. Dwell 0 behaves as dwell 1; settle 0 consumes no samples.
- `rst` low mid-SETTLE → all outputs 0 asynchronously. After release, a new `start` completes normally in NUM_DIRS×(settle+dwell+1)+1 cycles.
